// File: rtl/matrix_pkg.sv
// Shared geometry, colour-bit positions and control states for the LED matrix
// frame buffer and its row scanner.
package matrix_pkg;

  localparam int MAT_ROWS = 16;
  localparam int MAT_COLS = 8;

  localparam int R = 0;
  localparam int G = 1;
  localparam int B = 2;

  typedef enum logic [1:0] {
    ACCEPT,
    WAIT_SWAP,
    CLEAR
  } state_e;

endpackage

// File: rtl/matrix_row_scanner.sv
// Row scanner: walks the 16 matrix rows, holding each for ROW_CYCLES clocks,
// and drives registered row-select and blanked colour-column outputs.
module matrix_row_scanner
  import matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 3000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [MAT_COLS-1:0] row_r_i,
  input  logic [MAT_COLS-1:0] row_g_i,
  input  logic [MAT_COLS-1:0] row_b_i,
  output logic [3:0]          scan_row_o,
  output logic                frame_boundary_o,
  output logic [15:0]         row_sel_n_o,
  output logic [MAT_COLS-1:0] col_r_o,
  output logic [MAT_COLS-1:0] col_g_o,
  output logic [MAT_COLS-1:0] col_b_o
);

  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          row_q, row_d;
  logic                row_end;
  logic [15:0]         row_sel_n_q;
  logic [MAT_COLS-1:0] col_r_q, col_g_q, col_b_q;

  assign row_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = row_end ? '0 : cnt_q + 1'b1;
    row_d = row_end ? row_q + 1'b1 : row_q;
  end

  // Column drive lags the counters by one clock; the first BLANK_CYCLES of
  // every row stay dark so the previous row's image cannot ghost.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q       <= '0;
      row_q       <= '0;
      row_sel_n_q <= 16'hFFFF;
      col_r_q     <= '0;
      col_g_q     <= '0;
      col_b_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      row_sel_n_q <= ~(16'b1 << row_q);
      if (cnt_q >= BLANK) begin
        col_r_q <= row_r_i;
        col_g_q <= row_g_i;
        col_b_q <= row_b_i;
      end else begin
        col_r_q <= '0;
        col_g_q <= '0;
        col_b_q <= '0;
      end
    end
  end

  assign frame_boundary_o = row_end && (row_q == 4'(MAT_ROWS - 1));
  assign scan_row_o       = row_q;
  assign row_sel_n_o      = row_sel_n_q;
  assign col_r_o          = col_r_q;
  assign col_g_o          = col_g_q;
  assign col_b_o          = col_b_q;

endmodule

// File: rtl/matrix_scan_fb.sv
// Double-buffered 16x8 RGB frame buffer: captures the game pixel stream into
// the back bank and swaps banks only between scan frames so images never tear.
module matrix_scan_fb
  import matrix_pkg::*;
#(
  parameter int ROW_CYCLES   = 3000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic                pix_eof,
  input  logic [2:0]          pix_x,
  input  logic [3:0]          pix_y,
  input  logic [2:0]          pix_color,
  output logic [15:0]         row_sel_n,
  output logic [MAT_COLS-1:0] col_r,
  output logic [MAT_COLS-1:0] col_g,
  output logic [MAT_COLS-1:0] col_b,
  output logic [3:0]          scan_row,
  output logic                swap_pulse
);

  state_e              state_q;
  logic                front_q;
  logic                pending_q;
  logic                ready_q;
  logic                swap_q;
  logic [3:0]          clr_idx_q;
  logic [MAT_COLS-1:0] bank_q [2][MAT_ROWS][3];

  logic                xfer;
  logic                back_sel;
  logic                frame_boundary;
  logic [MAT_COLS-1:0] front_r, front_g, front_b;

  assign xfer     = pix_valid && ready_q;
  assign back_sel = ~front_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= ACCEPT;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      swap_q    <= 1'b0;
      clr_idx_q <= '0;
    end else begin
      swap_q <= 1'b0;
      case (state_q)
        ACCEPT: begin
          if (xfer && pix_eof) begin
            pending_q <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= WAIT_SWAP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (frame_boundary && pending_q) begin
            front_q   <= ~front_q;
            swap_q    <= 1'b1;
            pending_q <= 1'b0;
            clr_idx_q <= '0;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == 4'(MAT_ROWS - 1)) begin
            ready_q <= 1'b1;
            state_q <= ACCEPT;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  // After a swap the back bank holds the previously displayed frame, so it is
  // wiped row by row before the producer may draw into it again.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < MAT_ROWS; r++) begin
          for (int p = 0; p < 3; p++) begin
            bank_q[b][r][p] <= '0;
          end
        end
      end
    end else if (state_q == CLEAR) begin
      bank_q[back_sel][clr_idx_q][R] <= '0;
      bank_q[back_sel][clr_idx_q][G] <= '0;
      bank_q[back_sel][clr_idx_q][B] <= '0;
    end else if (xfer) begin
      bank_q[back_sel][pix_y][R][pix_x] <= pix_color[R];
      bank_q[back_sel][pix_y][G][pix_x] <= pix_color[G];
      bank_q[back_sel][pix_y][B][pix_x] <= pix_color[B];
    end
  end

  assign front_r = bank_q[front_q][scan_row][R];
  assign front_g = bank_q[front_q][scan_row][G];
  assign front_b = bank_q[front_q][scan_row][B];

  matrix_row_scanner #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scanner (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .row_r_i         (front_r),
    .row_g_i         (front_g),
    .row_b_i         (front_b),
    .scan_row_o      (scan_row),
    .frame_boundary_o(frame_boundary),
    .row_sel_n_o     (row_sel_n),
    .col_r_o         (col_r),
    .col_g_o         (col_g),
    .col_b_o         (col_b)
  );

  assign pix_ready  = ready_q;
  assign swap_pulse = swap_q;

endmodule

// File: tb/tb_matrix_scan_fb.sv
// Bench for matrix_scan_fb: image/position model checked every cycle plus
// directed pixel scenarios with literal expectations.
module tb_matrix_scan_fb;

  localparam int RC = 20;
  localparam int BC = 4;
  localparam int FR = RC * 16;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_eof = 1'b0;
  logic [2:0]  pix_x = '0;
  logic [3:0]  pix_y = '0;
  logic [2:0]  pix_color = '0;
  logic        pix_ready;
  logic [15:0] row_sel_n;
  logic [7:0]  col_r, col_g, col_b;
  logic [3:0]  scan_row;
  logic        swap_pulse;

  always #5 CLK = ~CLK;

  matrix_scan_fb #(
    .ROW_CYCLES  (RC),
    .BLANK_CYCLES(BC)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_eof   (pix_eof),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .row_sel_n (row_sel_n),
    .col_r     (col_r),
    .col_g     (col_g),
    .col_b     (col_b),
    .scan_row  (scan_row),
    .swap_pulse(swap_pulse)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: displayed and drawing images, elapsed scan time, and handshake.
  logic [2:0]  front_m [16][8];
  logic [2:0]  back_m  [16][8];
  int          k = 0;
  int          r_m, c_m;
  int          clear_left = 0;
  bit          started = 1'b0;
  bit          pending_m = 1'b0;
  bit          ready_m = 1'b0;
  logic [15:0] e_rs;
  logic [7:0]  e_r, e_g, e_b;
  logic [3:0]  e_sr;
  logic        e_sw;

  always @(posedge CLK) begin
    if (!RSTn) begin
      foreach (front_m[a, b]) front_m[a][b] = '0;
      foreach (back_m[a, b]) back_m[a][b] = '0;
      k = 0; pending_m = 0; clear_left = 0; ready_m = 0; started = 1;
      e_rs = 16'hFFFF; e_r = '0; e_g = '0; e_b = '0; e_sr = '0; e_sw = 0;
    end else if (started) begin
      r_m = (k / RC) % 16;
      c_m = k % RC;
      e_rs = ~(16'b1 << r_m);
      for (int i = 0; i < 8; i++) begin
        e_r[i] = (c_m >= BC) ? front_m[r_m][i][0] : 1'b0;
        e_g[i] = (c_m >= BC) ? front_m[r_m][i][1] : 1'b0;
        e_b[i] = (c_m >= BC) ? front_m[r_m][i][2] : 1'b0;
      end
      e_sw = 0;
      if (pending_m && c_m == RC - 1 && r_m == 15) begin
        front_m = back_m;
        foreach (back_m[a, b]) back_m[a][b] = '0;
        e_sw = 1; pending_m = 0; clear_left = 16;
      end else if (clear_left > 0) begin
        clear_left--;
      end else if (pix_valid && ready_m) begin
        back_m[pix_y][pix_x] = pix_color;
        if (pix_eof) pending_m = 1;
      end
      ready_m = !pending_m && (clear_left == 0);
      k++;
      e_sr = 4'((k / RC) % 16);
    end
  end

  task automatic compare_cycle();
    n_tests++;
    if ({row_sel_n, col_r, col_g, col_b, scan_row, swap_pulse, pix_ready} !==
        {e_rs, e_r, e_g, e_b, e_sr, e_sw, ready_m}) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL model k=%0d got rs=%h r=%h g=%h b=%h row=%0d sw=%b rdy=%b want rs=%h r=%h g=%h b=%h row=%0d sw=%b rdy=%b",
                 k, row_sel_n, col_r, col_g, col_b, scan_row, swap_pulse, pix_ready,
                 e_rs, e_r, e_g, e_b, e_sr, e_sw, ready_m);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (started) compare_cycle();
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm, input int n);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles", nm, n);
  endtask

  // Wait until the outputs show scan row r at row-cycle count c.
  task automatic wait_out(input int r, input int c);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((((k - 1) % FR) != (r * RC + c)) && (n < 2 * FR));
    if (((k - 1) % FR) != (r * RC + c)) timeout("wait_out", n);
  endtask

  task automatic wait_swap();
    int n;
    n = 0;
    while (swap_pulse !== 1'b1 && n < 2 * FR + 64) begin
      tick();
      n++;
    end
    if (swap_pulse !== 1'b1) timeout("wait_swap", n);
  endtask

  // Present a pixel and hold it until one transfer; leaves pix_valid asserted.
  task automatic send(input int x, input int y, input logic [2:0] c, input logic eof);
    int n;
    pix_x = 3'(x); pix_y = 4'(y); pix_color = c; pix_eof = eof; pix_valid = 1'b1;
    n = 0;
    while (pix_ready !== 1'b1 && n < 3 * FR) begin
      tick();
      n++;
    end
    if (pix_ready !== 1'b1) timeout("send", n);
    tick();
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
  endtask

  initial begin
    int cnt;
    // 1: reset and dark first frame
    RSTn = 1'b0;
    repeat (3) tick();
    check("rst_row_sel", 32'(row_sel_n), 32'hFFFF);
    check("rst_cols", 32'({col_r, col_g, col_b}), 32'h0);
    check("rst_ready", 32'(pix_ready), 32'h0);
    RSTn = 1'b1;
    tick();
    check("rel_ready", 32'(pix_ready), 32'h1);
    check("rel_row_sel", 32'(row_sel_n), 32'hFFFE);
    wait_out(15, 19);

    // 2: single red pixel at (3,5)
    send(3, 5, 3'b001, 1'b1);
    idle();
    check("eof_ready_low", 32'(pix_ready), 32'h0);
    wait_swap();
    cnt = 0;
    while (pix_ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("swap_to_ready", 32'(cnt), 32'd16);
    wait_out(5, 3);
    check("r5_blank_sel", 32'(row_sel_n), 32'hFFDF);
    check("r5_blank_r", 32'(col_r), 32'h00);
    wait_out(5, 4);
    check("r5_on_r", 32'(col_r), 32'h08);
    wait_out(5, 19);
    check("r5_end_r", 32'(col_r), 32'h08);
    wait_out(6, 10);
    check("r6_sel", 32'(row_sel_n), 32'hFFBF);
    check("r6_dark", 32'({col_r, col_g, col_b}), 32'h0);

    // 3: pixel held during WAIT_SWAP/CLEAR is written exactly once
    send(6, 2, 3'b001, 1'b1);
    check("wait_ready_low", 32'(pix_ready), 32'h0);
    send(1, 9, 3'b100, 1'b1);
    check("held_ready_low", 32'(pix_ready), 32'h0);
    idle();
    wait_swap();
    wait_out(9, 5);
    check("r9_sel", 32'(row_sel_n), 32'hFDFF);
    check("r9_b", 32'(col_b), 32'h02);
    wait_out(2, 5);
    check("r2_cleared", 32'({col_r, col_g, col_b}), 32'h0);

    // 4: back bank cleared between frames
    send(3, 5, 3'b111, 1'b1);
    idle();
    wait_swap();
    send(0, 0, 3'b010, 1'b1);
    idle();
    wait_swap();
    wait_out(0, 4);
    check("r0_g", 32'(col_g), 32'h01);
    wait_out(5, 10);
    check("r5_cleared", 32'({col_r, col_g, col_b}), 32'h0);

    // 5: last write to a coordinate wins
    send(2, 7, 3'b100, 1'b0);
    send(2, 7, 3'b010, 1'b1);
    idle();
    wait_swap();
    wait_out(7, 6);
    check("r7_g", 32'(col_g), 32'h04);
    check("r7_b", 32'(col_b), 32'h00);

    // 6: reset during CLEAR
    send(4, 4, 3'b011, 1'b1);
    idle();
    wait_swap();
    repeat (3) tick();
    RSTn = 1'b0;
    tick();
    check("mid_rst_sel", 32'(row_sel_n), 32'hFFFF);
    check("mid_rst_cols", 32'({col_r, col_g, col_b}), 32'h0);
    check("mid_rst_ready", 32'(pix_ready), 32'h0);
    check("mid_rst_row", 32'(scan_row), 32'h0);
    RSTn = 1'b1;
    tick();
    check("mid_rel_ready", 32'(pix_ready), 32'h1);
    wait_out(4, 8);
    check("r4_dark", 32'({col_r, col_g, col_b}), 32'h0);
    wait_out(15, 19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_scan_fb.md
Name: matrix_scan_fb

Overview:
- Downstream consumer of the game-logic pixel stream, which emits one {color, y, x} pixel per strobe, cycling over all snake segments.
- Captures pixels into a double-buffered 8x16 RGB frame buffer.
- Row-scans the front buffer onto the 16-row x 8-column RGB LED matrix.
- Sits between the game FSM and the matrix pins. Replaces the raw single-pixel LED output with a persistent, flicker-free image.

Parameters:
- ROW_CYCLES, 3000: CLK cycles each row stays selected. Minimum BLANK_CYCLES+1.
- BLANK_CYCLES, 16: cycles at the start of each row with all column outputs forced off (anti-ghosting).

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset
- pix_valid  in  1  producer has a pixel
- pix_ready  out  1  block accepts a pixel this cycle
- pix_eof  in  1  qualifies the accepted pixel as the last pixel of a frame
- pix_x  in  3  column 0..7
- pix_y  in  4  row 0..15
- pix_color  in  3  bit0=R, bit1=G, bit2=B; 3'b000 = off
- row_sel_n  out  16  one-hot active-low row drive
- col_r  out  8  red column drive, active-high, bit i = column i
- col_g  out  8  green column drive
- col_b  out  8  blue column drive
- scan_row  out  4  row currently selected
- swap_pulse  out  1  one-cycle pulse on a buffer swap

Interface decision: one clock, CLK; reset RSTn is synchronous and active-low.

Behaviour:
- Reset (RSTn=0 at a CLK edge):
  - both banks cleared to 0; front bank = 0; swap_pending=0; state=ACCEPT
  - scan_row=0; row cycle counter=0
  - row_sel_n=16'hFFFF; col_r/g/b=0; swap_pulse=0; pix_ready=0
- Reset asserted mid-frame or mid-clear abandons all contents with no partial writes.
- pix_ready goes 1 on the first edge with RSTn=1.
- Handshake:
  - A transfer occurs when pix_valid && pix_ready at a CLK edge.
  - On transfer, back[pix_y][pix_x] <= pix_color.
  - Last write to a coordinate wins; writes never touch the front bank.
- State machine:
  - ACCEPT: pix_ready=1. A transfer with pix_eof=1 writes the pixel, sets swap_pending, and moves to WAIT_SWAP.
  - WAIT_SWAP: pix_ready=0. Waits for the scan frame boundary: row cycle counter == ROW_CYCLES-1 and scan_row == 15.
  - At that edge:
    - the front-bank select toggles
    - swap_pulse=1 for the following cycle
    - swap_pending clears
    - the state moves to CLEAR with clear index 0
  - CLEAR: pix_ready=0. Zeroes one 24-bit row of the new back bank (the old front bank) per cycle, rows 0..15. This takes 16 cycles, then the state returns to ACCEPT.
  - Frames therefore never tear: the front bank changes only between scan frames.
- Scan:
  - The row cycle counter counts 0..ROW_CYCLES-1 and wraps.
  - On wrap, scan_row increments, and 15 wraps to 0.
  - Outputs are registered, one cycle behind counter and scan_row:
    - row_sel_n = ~(16'b1 << scan_row)
    - col_* = front[scan_row] colour planes when counter >= BLANK_CYCLES, else 8'h00
- A swap at the frame boundary takes effect from row 0 of the next scan frame.
- Bounds: the x and y widths exactly cover the matrix, so there is no out-of-range case.
- Width rules: the counter width is $clog2(ROW_CYCLES); comparisons are unsigned.

Decomposition:
- Package matrix_pkg holds:
  - MAT_ROWS=16, MAT_COLS=8
  - the colour-bit index constants R=0, G=1, B=2
  - the state enum {ACCEPT, WAIT_SWAP, CLEAR}
- One sub-module, matrix_row_scanner: the row cycle counter, the scan_row counter, blanking, and registered row/column drive. It exports a frame_boundary strobe to the parent.
- The parent owns both banks, the handshake, and the FSM.

Test Plan (ROW_CYCLES=20, BLANK_CYCLES=4):
1. Hold RSTn=0 for 3 cycles -> row_sel_n=16'hFFFF, col_*=0, pix_ready=0. After release: pix_ready=1, row_sel_n=16'hFFFE, col_*=0 for the full scan frame.
2. Send pixel x=3,y=5,color=3'b001 with eof -> pix_ready=0 until swap_pulse plus 16 cycles. In the next scan frame, row 5 (row_sel_n=16'hFFDF) shows col_r=8'h08 from counter 4..19 and 8'h00 during counter 0..3; every other row is dark.
3. Hold pix_valid=1 with a different pixel during WAIT_SWAP and CLEAR -> it is not written until pix_ready returns. Exactly one write then occurs, visible after the following swap.
4. Frame 1 writes (3,5)=3'b111; frame 2 writes only (0,0)=3'b010 with eof -> after the second swap, row 0 shows col_g=8'h01 and row 5 is dark (back bank cleared).
5. Write (2,7)=3'b100, then (2,7)=3'b010 with eof -> row 7 shows col_g=8'h04, col_b=8'h00 (last write wins).
6. Assert RSTn=0 for 1 cycle during CLEAR -> all outputs return to reset values, and the matrix is fully dark on the next scan frame.
